// File: rtl/alu_result_display_scan.sv
// Purpose: converts an accepted ALU result byte to BCD and scans it onto a 4-digit active-low 7-segment display (hex option: ALU_DISP_HEX_EN).
// Latency: load accepted at edge N -> bcd_o updated and bcd_valid_o pulsed after edge N+9; display follows bcd_o immediately.
// Backpressure: ready_o low while a conversion is in flight; loads seen while not ready are dropped, not queued.
module alu_result_display_scan #(
    parameter int REFRESH_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value_i,
    input  logic        load_i,
`ifdef ALU_DISP_HEX_EN
    input  logic        hex_mode_i,
`endif
    output logic        ready_o,
    output logic [11:0] bcd_o,
    output logic        bcd_valid_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        dp_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         accept;

    logic [7:0]   op_q;
    logic [11:0]  scr_q;
    logic [11:0]  scr_adj;
    logic [2:0]   bit_q;
    logic [11:0]  bcd_q;
    logic         vld_q;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;

    logic [3:0]   ones;
    logic [3:0]   tens;
    logic [3:0]   hund;

`ifdef ALU_DISP_HEX_EN
    logic [7:0]   raw_q;
    logic         hexm_q;
    logic [7:0]   disp_raw_q;
    logic         disp_hex_q;
`endif

    // Active-low segment pattern {g,f,e,d,c,b,a} for one nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [11:0] dabble_adj(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign scr_adj = dabble_adj(scr_q);
    assign accept  = ready_o & load_i;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake: only IDLE accepts, SHIFT runs 8 edges, COMMIT is one edge.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (load_i) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operand, shift-add-3 through the scratch, publish on COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            scr_q <= '0;
            bit_q <= '0;
            bcd_q <= '0;
            vld_q <= 1'b0;
`ifdef ALU_DISP_HEX_EN
            raw_q      <= '0;
            hexm_q     <= 1'b0;
            disp_raw_q <= '0;
            disp_hex_q <= 1'b0;
`endif
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= value_i;
                        scr_q <= '0;
                        bit_q <= '0;
`ifdef ALU_DISP_HEX_EN
                        raw_q  <= value_i;
                        hexm_q <= hex_mode_i;
`endif
                    end
                end
                SHIFT: begin
                    {scr_q, op_q} <= {scr_adj, op_q} << 1;
                    bit_q         <= bit_q + 3'd1;
                end
                COMMIT: begin
                    bcd_q <= scr_q;
                    vld_q <= 1'b1;
`ifdef ALU_DISP_HEX_EN
                    disp_raw_q <= raw_q;
                    disp_hex_q <= hexm_q;
`endif
                end
                default: ;
            endcase
        end
    end

    // Refresh prescaler: each digit slot is held for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ones = bcd_q[3:0];
    assign tens = bcd_q[7:4];
    assign hund = bcd_q[11:8];

    // Digit decode from committed value only; slot 3 is a dummy slot to keep 1/4 duty.
    always_comb begin
        an_o  = 4'b1111;
        seg_o = 7'h7F;
        case (idx_q)
            2'd0: begin
                an_o  = 4'b1110;
                seg_o = seg_code(ones);
            end
            2'd1: begin
                if ((hund != 4'd0) || (tens != 4'd0)) begin
                    an_o  = 4'b1101;
                    seg_o = seg_code(tens);
                end
            end
            2'd2: begin
                if (hund != 4'd0) begin
                    an_o  = 4'b1011;
                    seg_o = seg_code(hund);
                end
            end
            default: ;
        endcase
`ifdef ALU_DISP_HEX_EN
        if (disp_hex_q) begin
            an_o  = 4'b1111;
            seg_o = 7'h7F;
            case (idx_q)
                2'd0: begin
                    an_o  = 4'b1110;
                    seg_o = seg_code(disp_raw_q[3:0]);
                end
                2'd1: begin
                    an_o  = 4'b1101;
                    seg_o = seg_code(disp_raw_q[7:4]);
                end
                default: ;
            endcase
        end
`endif
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = vld_q;
    assign dp_o        = 1'b1;

endmodule
